cruise_alu: RTL and testbench



---
 rtl/cruise_alu_if.sv | 24 ++
 rtl/cruise_alu.sv | 80 ++++++++
 tb/tb_cruise_alu.sv | 108 ++++++++++
 3 files changed

// File: rtl/cruise_alu_if.sv
// Operand/result bundle between the cruise-control FSM and its ALU.
// The master side drives the mode and the two speeds, and the slave side returns
// the registered flags and the result speed.
interface cruise_alu_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       mode;
    logic [WIDTH-1:0] d_speed;
    logic [WIDTH-1:0] c_speed;
    logic             G;
    logic             EQ;
    logic             L;
    logic [WIDTH-1:0] out_speed;

    modport master (
        output mode, d_speed, c_speed,
        input  G, EQ, L, out_speed
    );

    modport slave (
        input  mode, d_speed, c_speed,
        output G, EQ, L, out_speed
    );
endinterface

// File: rtl/cruise_alu.sv
// Registered compare/arithmetic unit for the cruise-control datapath.
// Each edge it registers the d_speed vs c_speed magnitude flags together with a
// new speed chosen by mode: pass-through, saturating add, saturating subtract,
// or a single step toward the set-point. The latency is one cycle, and the
// only state is the output registers.
module cruise_alu #(
    parameter int WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    cruise_alu_if.slave  bus
);
    localparam logic [1:0] MODE_CMP  = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;

    logic             r_g;
    logic             r_eq;
    logic             r_l;
    logic [WIDTH-1:0] r_out;

    // Unsigned magnitude compare. Exactly one of the three flags is true.
    assign w_gt = (bus.d_speed >  bus.c_speed);
    assign w_eq = (bus.d_speed == bus.c_speed);
    assign w_lt = (bus.d_speed <  bus.c_speed);

    // The add keeps the carry so an overflow clamps to all-ones instead of wrapping.
    assign w_sum = {1'b0, bus.c_speed} + {1'b0, bus.d_speed};
    assign w_add = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

    // The subtract clamps to zero when the current speed exceeds the set-point.
    assign w_sub = w_lt ? {WIDTH{1'b0}} : (bus.d_speed - bus.c_speed);

    // The step moves only strictly toward d_speed, so it can never wrap at 0 or max.
    assign w_step = w_gt ? (bus.c_speed + WIDTH'(1)) :
                    w_lt ? (bus.c_speed - WIDTH'(1)) :
                           bus.c_speed;

    // Select the result for this edge from the mode.
    always_comb begin
        w_next = bus.c_speed;
        case (bus.mode)
            MODE_CMP:  w_next = bus.c_speed;
            MODE_ADD:  w_next = w_add;
            MODE_SUB:  w_next = w_sub;
            MODE_STEP: w_next = w_step;
            default:   w_next = bus.c_speed;
        endcase
    end

    // Flags and result load on the same edge. Reset clears them at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_g   <= 1'b0;
            r_eq  <= 1'b0;
            r_l   <= 1'b0;
            r_out <= '0;
        end else begin
            r_g   <= w_gt;
            r_eq  <= w_eq;
            r_l   <= w_lt;
            r_out <= w_next;
        end
    end

    assign bus.G         = r_g;
    assign bus.EQ        = r_eq;
    assign bus.L         = r_l;
    assign bus.out_speed = r_out;
endmodule

// File: tb/tb_cruise_alu.sv
// Directed bench for cruise_alu. Each vector is driven on a negedge and sampled
// 1 time unit after the following posedge. Each observation is packed as
// {out_speed, G, EQ, L}.
module tb_cruise_alu;
    localparam int WIDTH = 8;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;

    cruise_alu_if #(.WIDTH(WIDTH)) bus ();

    cruise_alu #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [WIDTH+2:0] exp);
        logic [WIDTH+2:0] obs;
        obs = {bus.out_speed, bus.G, bus.EQ, bus.L};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed out=%h G/EQ/L=%b required out=%h G/EQ/L=%b",
                   tag, obs[WIDTH+2:3], obs[2:0], exp[WIDTH+2:3], exp[2:0]);
        end
    endtask

    // Drive one vector, let one edge pass, then compare against the expected result.
    task automatic vec(input string tag, input logic [1:0] m, input logic [7:0] d,
                       input logic [7:0] c, input logic [7:0] eout, input logic [2:0] eflg);
        @(negedge clock);
        bus.mode    = m;
        bus.d_speed = d;
        bus.c_speed = c;
        @(posedge clock);
        #1;
        chk(tag, {eout, eflg});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset       = 1'b1;
        bus.mode    = 2'b01;
        bus.d_speed = 8'h33;
        bus.c_speed = 8'h44;
        #2;
        chk("reset_initial", 11'h000);
        @(posedge clock);
        #1;
        chk("reset_held_edge", 11'h000);
        @(negedge clock);
        reset = 1'b0;

        // The flags are encoded as G EQ L.
        vec("cmp_8_1",      2'b00, 8'h08, 8'h01, 8'h01, 3'b100);
        vec("cmp_ab_ab",    2'b00, 8'hAB, 8'hAB, 8'hAB, 3'b010);
        vec("add_28_11",    2'b01, 8'h28, 8'h11, 8'h39, 3'b100);
        vec("add_f0_20_sat",2'b01, 8'hF0, 8'h20, 8'hFF, 3'b100);
        vec("add_ff_01_sat",2'b01, 8'hFF, 8'h01, 8'hFF, 3'b100);
        vec("add_80_7f",    2'b01, 8'h80, 8'h7F, 8'hFF, 3'b100);
        vec("add_7f_80",    2'b01, 8'h7F, 8'h80, 8'hFF, 3'b001);
        vec("sub_8_1",      2'b10, 8'h08, 8'h01, 8'h07, 3'b100);
        vec("sub_1_8_sat",  2'b10, 8'h01, 8'h08, 8'h00, 3'b001);
        vec("sub_ff_00",    2'b10, 8'hFF, 8'h00, 8'hFF, 3'b100);
        vec("sub_42_42",    2'b10, 8'h42, 8'h42, 8'h00, 3'b010);
        vec("step_up",      2'b11, 8'h08, 8'h01, 8'h02, 3'b100);
        vec("step_down",    2'b11, 8'h01, 8'h08, 8'h07, 3'b001);
        vec("step_eq",      2'b11, 8'h55, 8'h55, 8'h55, 3'b010);
        vec("step_top",     2'b11, 8'hFF, 8'hFE, 8'hFF, 3'b100);
        vec("step_bottom",  2'b11, 8'h00, 8'h01, 8'h00, 3'b001);
        vec("step_ff_00",   2'b11, 8'hFF, 8'h00, 8'h01, 3'b100);
        vec("step_00_ff",   2'b11, 8'h00, 8'hFF, 8'hFE, 3'b001);
        vec("add_zero",     2'b01, 8'h00, 8'h00, 8'h00, 3'b010);
        vec("cmp_after_add",2'b00, 8'h10, 8'h90, 8'h90, 3'b001);

        // The result must hold until the next edge even after the inputs change.
        @(negedge clock);
        bus.mode    = 2'b01;
        bus.d_speed = 8'h01;
        bus.c_speed = 8'h02;
        #2;
        chk("hold_until_edge", {8'h90, 3'b001});
        @(posedge clock);
        #1;
        chk("load_after_edge", {8'h03, 3'b001});

        // Assert reset mid-cycle. The outputs must clear with no clock edge.
        vec("pre_reset",    2'b11, 8'h20, 8'h10, 8'h11, 3'b100);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 11'h000);
        vec("reset_blocks", 2'b01, 8'h05, 8'h06, 8'h00, 3'b000);
        @(negedge clock);
        reset = 1'b0;
        vec("post_reset",   2'b10, 8'h09, 8'h04, 8'h05, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
